// File: rtl/ids_bus_pkg.sv
// rtl/ids_bus_pkg.sv - shared bus widths, beat size and master state encoding
package ids_bus_pkg;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int LEN_W_DEF      = 16;
    localparam int BYTES_PER_BEAT = DATA_W_DEF / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ids_bus_master.sv
// rtl/ids_bus_master.sv - DMA-side bus master issuing preemptible bursts over req/gnt
module ids_bus_master
    import ids_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [LEN_W-1:0]  i_cmd_len,
    input  logic              i_cmd_write,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_wdata_valid,
    output logic              o_wdata_ready,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rdata_valid,
    output logic              o_req,
    input  logic              i_gnt,
    output logic              o_bus_valid,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic [DATA_W-1:0] i_bus_rdata,
    output logic              o_busy,
    output logic              o_done
);

    // Address step per beat, sized to the address bus so the add wraps silently.
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              write_q, write_d;
    logic              rdv_q, rdv_d;
    logic              fire;

    // State and burst context registers; reset discards any in-flight burst.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            write_q <= 1'b0;
            rdv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            write_q <= write_d;
            rdv_q   <= rdv_d;
        end
    end

    // Next-state and bus outputs: one beat per granted cycle, stall while grant is withdrawn.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        write_d       = write_q;
        rdv_d         = 1'b0;
        fire          = 1'b0;
        o_cmd_ready   = 1'b0;
        o_req         = 1'b0;
        o_bus_valid   = 1'b0;
        o_bus_we      = 1'b0;
        o_bus_addr    = '0;
        o_bus_wdata   = '0;
        o_wdata_ready = 1'b0;
        o_done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    addr_d  = i_cmd_addr;
                    rem_d   = i_cmd_len;
                    write_d = i_cmd_write;
                    state_d = (i_cmd_len == '0) ? ST_DONE : ST_BUS;
                end
            end
            ST_BUS: begin
                o_req         = 1'b1;
                fire          = i_gnt && (write_q ? i_wdata_valid : 1'b1);
                o_bus_valid   = fire;
                o_bus_we      = write_q;
                o_bus_addr    = addr_q;
                o_bus_wdata   = i_wdata;
                o_wdata_ready = i_gnt && write_q;
                rdv_d         = fire && !write_q;
                if (fire) begin
                    addr_d = addr_q + ADDR_STEP;
                    rem_d  = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = write_q ? ST_DONE : ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_rdata       = i_bus_rdata;
    assign o_rdata_valid = rdv_q;

endmodule
